// File: rtl/alarm_seq_ctrl_if.sv
// alarm_seq_ctrl_if: groups the button, time-of-day and setpoint inputs with
// the trigger/status outputs of the alarm sequencer. Clock and reset are
// plain ports on the modules themselves.
interface alarm_seq_ctrl_if;
   logic       set_btn;
   logic       stop_btn;
   logic       snooze_btn;
   logic       alarm_en;
   logic [4:0] hh_now;
   logic [5:0] mm_now;
   logic [4:0] alm_hh_in;
   logic [5:0] alm_mm_in;

   logic       trigger;
   logic [4:0] alm_hh;
   logic [5:0] alm_mm;
   logic       ringing;
   logic       snoozing;
   logic [2:0] ctrl_state;

   // Drives the buttons/time and observes the sequencer
   modport master (
      output set_btn, stop_btn, snooze_btn, alarm_en,
      output hh_now, mm_now, alm_hh_in, alm_mm_in,
      input  trigger, alm_hh, alm_mm, ringing, snoozing, ctrl_state
   );

   // The sequencer itself
   modport slave (
      input  set_btn, stop_btn, snooze_btn, alarm_en,
      input  hh_now, mm_now, alm_hh_in, alm_mm_in,
      output trigger, alm_hh, alm_mm, ringing, snoozing, ctrl_state
   );
endinterface

// File: rtl/alarm_seq_ctrl.sv
// alarm_seq_ctrl: turns button edges, the time-of-day match and second
// timers into single-cycle trigger pulses for the idle/load/alarm FSM,
// holds the alarm setpoint and reports the sequencer state.
// Optional feature macro: ALARM_SNOOZE_EN (adds SNZ_GAP/SNOOZE states).
module alarm_seq_ctrl #(
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300
) (
   input  logic             m_clk,
   input  logic             m_reset,
   alarm_seq_ctrl_if.slave  bus
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef ALARM_SNOOZE_EN
   localparam int unsigned CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
`else
   localparam int unsigned CNT_MAX = RING_SECS;
`endif
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] RING_END   = CNT_W'(RING_SECS);
`ifdef ALARM_SNOOZE_EN
   localparam logic [CNT_W-1:0] SNOOZE_END = CNT_W'(SNOOZE_SECS);
`endif

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
`ifdef ALARM_SNOOZE_EN
      ST_SNZ_GAP = 3'd3,
      ST_SNOOZE  = 3'd4,
`endif
      ST_RING    = 3'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sec_tick;

   logic             set_s_q, set_s_d, set_p_q, set_p_d;
   logic             stop_s_q, stop_s_d, stop_p_q, stop_p_d;
   logic             set_edge, stop_edge;
`ifdef ALARM_SNOOZE_EN
   logic             snz_s_q, snz_s_d, snz_p_q, snz_p_d;
   logic             snz_edge;
   logic             gap_q, gap_d;
`else
   logic             unused_snooze;
`endif

   logic             match_now, match_load, match_q, match_d, match_edge;
   logic             hold;

   logic             trigger_q, trigger_d;
   logic             ringing_q, ringing_d;
   logic             snoozing_q, snoozing_d;
   logic [4:0]       alm_hh_q, alm_hh_d;
   logic [5:0]       alm_mm_q, alm_mm_d;

   assign sec_tick   = (pre_q == PRE_LAST);
   assign set_edge   = set_s_q & ~set_p_q;
   assign stop_edge  = stop_s_q & ~stop_p_q;
`ifdef ALARM_SNOOZE_EN
   assign snz_edge   = snz_s_q & ~snz_p_q;
`else
   assign unused_snooze = bus.snooze_btn;
`endif

   assign match_now  = bus.alarm_en & (bus.hh_now == alm_hh_q) & (bus.mm_now == alm_mm_q);
   // Match value the new setpoint would give; loaded on latch so arming inside
   // the matching minute waits for the next occurrence
   assign match_load = bus.alarm_en & (bus.hh_now == bus.alm_hh_in) & (bus.mm_now == bus.alm_mm_in);
   assign match_edge = match_now & ~match_q;

   // While a trigger is high no new trigger may be issued; the previous-sample
   // registers freeze so any edge arriving then is served one cycle later
   assign hold = trigger_q;

   assign bus.trigger    = trigger_q;
   assign bus.alm_hh     = alm_hh_q;
   assign bus.alm_mm     = alm_mm_q;
   assign bus.ringing    = ringing_q;
   assign bus.snoozing   = snoozing_q;
   assign bus.ctrl_state = state_q;

   // Next-state, trigger, timers, edge samplers and setpoint
   always_comb begin
      state_d   = state_q;
      trigger_d = 1'b0;
      alm_hh_d  = alm_hh_q;
      alm_mm_d  = alm_mm_q;
      match_d   = hold ? match_q : match_now;
      pre_d     = sec_tick ? '0 : pre_q + 1'b1;

      set_s_d   = bus.set_btn;
      stop_s_d  = bus.stop_btn;
      set_p_d   = hold ? set_p_q  : set_s_q;
      stop_p_d  = hold ? stop_p_q : stop_s_q;
`ifdef ALARM_SNOOZE_EN
      snz_s_d   = bus.snooze_btn;
      snz_p_d   = hold ? snz_p_q : snz_s_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (set_edge && !hold) begin
               alm_hh_d  = bus.alm_hh_in;
               alm_mm_d  = bus.alm_mm_in;
               match_d   = match_load;
               trigger_d = 1'b1;
               state_d   = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (set_edge) begin
               alm_hh_d = bus.alm_hh_in;
               alm_mm_d = bus.alm_mm_in;
               match_d  = match_load;
            end else if (match_edge && !hold) begin
               trigger_d = 1'b1;
               state_d   = ST_RING;
            end
         end
         ST_RING: begin
            if (!hold) begin
               if (stop_edge || (cnt_q == RING_END)) begin
                  trigger_d = 1'b1;
                  state_d   = ST_IDLE;
               end
`ifdef ALARM_SNOOZE_EN
               else if (snz_edge) begin
                  trigger_d = 1'b1;
                  state_d   = ST_SNZ_GAP;
               end
`endif
            end
         end
`ifdef ALARM_SNOOZE_EN
         ST_SNZ_GAP: begin
            if (gap_q) begin
               trigger_d = 1'b1;
               state_d   = ST_SNOOZE;
            end
         end
         ST_SNOOZE: begin
            if (!hold && (cnt_q == SNOOZE_END)) begin
               trigger_d = 1'b1;
               state_d   = ST_RING;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (sec_tick && (cnt_q != CNT_SAT)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end

`ifdef ALARM_SNOOZE_EN
      gap_d      = (state_q == ST_SNZ_GAP) && (state_d == ST_SNZ_GAP);
      snoozing_d = (state_d == ST_SNZ_GAP) || (state_d == ST_SNOOZE);
`else
      snoozing_d = 1'b0;
`endif
      ringing_d  = (state_d == ST_RING);
   end

   // All sequencer state and registered outputs
   always_ff @(posedge m_clk or posedge m_reset) begin
      if (m_reset) begin
         state_q    <= ST_IDLE;
         pre_q      <= '0;
         cnt_q      <= '0;
         set_s_q    <= 1'b0;
         set_p_q    <= 1'b0;
         stop_s_q   <= 1'b0;
         stop_p_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snz_s_q    <= 1'b0;
         snz_p_q    <= 1'b0;
         gap_q      <= 1'b0;
`endif
         match_q    <= 1'b0;
         trigger_q  <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
         alm_hh_q   <= '0;
         alm_mm_q   <= '0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         set_s_q    <= set_s_d;
         set_p_q    <= set_p_d;
         stop_s_q   <= stop_s_d;
         stop_p_q   <= stop_p_d;
`ifdef ALARM_SNOOZE_EN
         snz_s_q    <= snz_s_d;
         snz_p_q    <= snz_p_d;
         gap_q      <= gap_d;
`endif
         match_q    <= match_d;
         trigger_q  <= trigger_d;
         ringing_q  <= ringing_d;
         snoozing_q <= snoozing_d;
         alm_hh_q   <= alm_hh_d;
         alm_mm_q   <= alm_mm_d;
      end
   end

endmodule
